// File: rtl/riscv_core_pkg.sv
// Types and constants shared by the memory pipe: funct3 width codes, FSM
// states, access-type encoding and the alignment-fault rule.
package riscv_core;

  localparam int ADDR_WIDTH = 32;
  localparam int NUM_PR     = 64;
  localparam int AL_SIZE    = 32;

  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

  typedef enum logic [2:0] {
    MW_B  = 3'b000,
    MW_H  = 3'b001,
    MW_W  = 3'b010,
    MW_BU = 3'b100,
    MW_HU = 3'b101
  } mem_width_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Unknown funct3 codes fault just like a misaligned access.
  function automatic logic mem_fault(input logic [2:0] width, input logic [1:0] off);
    case (width)
      MW_B, MW_BU: return 1'b0;
      MW_H, MW_HU: return off[0];
      MW_W:        return off != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_data_align.sv
// Selects the addressed byte/half/word lane of a load word and extends it.
module load_data_align
  import riscv_core::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_i,
  input  logic [2:0]  width_i,
  output logic [31:0] data_o
);

  logic [31:0] lane;

  assign lane = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    case (width_i)
      MW_B:    data_o = {{24{lane[7]}}, lane[7:0]};
      MW_H:    data_o = {{16{lane[15]}}, lane[15:0]};
      MW_BU:   data_o = {24'b0, lane[7:0]};
      MW_HU:   data_o = {16'b0, lane[15:0]};
      default: data_o = lane;
    endcase
  end

endmodule

// File: rtl/mem_exec_unit.sv
// Single-outstanding memory execution unit: address generation, dmem
// request/ack handshake, load alignment and writeback reporting.
module mem_exec_unit
  import riscv_core::*;
#(
  parameter int ADDR_WIDTH = riscv_core::ADDR_WIDTH,
  parameter int PR_W       = $clog2(riscv_core::NUM_PR),
  parameter int AL_W       = $clog2(riscv_core::AL_SIZE)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  miq_valid,
  input  logic [PR_W-1:0]       miq_rd,
  input  logic                  miq_uses_rd,
  input  logic [31:0]           miq_imm,
  input  logic                  miq_mem_access_type,
  input  logic [2:0]            miq_width,
  input  logic [AL_W-1:0]       miq_al_addr,
  input  logic [31:0]           rs1_data,
  input  logic [31:0]           rs2_data,
  input  logic                  kill,
  output logic                  busy,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata,
  output logic                  wb_valid,
  output logic [PR_W-1:0]       wb_rd,
  output logic                  wb_uses_rd,
  output logic [31:0]           wb_data,
  output logic [AL_W-1:0]       wb_al_addr,
  output logic                  wb_exception
);

  mem_state_e state_q, state_d;

  logic [31:0]     addr_q, rs2_q, ld_data_q;
  logic [PR_W-1:0] rd_q;
  logic [AL_W-1:0] al_q;
  logic [2:0]      width_q;
  logic            uses_rd_q, is_store_q, exc_q;
  logic            killed_q, killed_d;

  logic [31:0] eff_addr, ld_aligned, st_wdata;
  logic [3:0]  st_be;
  logic        accept, fault;

  assign eff_addr = rs1_data + miq_imm;
  assign fault    = mem_fault(miq_width, eff_addr[1:0]);
  assign accept   = (state_q == ST_IDLE) && miq_valid && !kill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = fault ? ST_RESP : ST_REQ;
      ST_REQ:  if (dmem_ack) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The kill is remembered through the rest of the handshake and cleared on
  // the way back to IDLE, so it never leaks into the next op.
  assign killed_d = (state_q == ST_REQ) ? (killed_q | kill) : 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= '0;
      rs2_q      <= '0;
      ld_data_q  <= '0;
      rd_q       <= '0;
      al_q       <= '0;
      width_q    <= '0;
      uses_rd_q  <= 1'b0;
      is_store_q <= 1'b0;
      exc_q      <= 1'b0;
      killed_q   <= 1'b0;
    end else begin
      killed_q <= killed_d;
      if (accept) begin
        addr_q     <= eff_addr;
        rs2_q      <= rs2_data;
        rd_q       <= miq_rd;
        al_q       <= miq_al_addr;
        width_q    <= miq_width;
        uses_rd_q  <= miq_uses_rd;
        is_store_q <= miq_mem_access_type;
        exc_q      <= fault;
      end
      if (state_q == ST_REQ && dmem_ack) ld_data_q <= ld_aligned;
    end
  end

  load_data_align u_align (
    .rdata_i (dmem_rdata),
    .addr_i  (addr_q[1:0]),
    .width_i (width_q),
    .data_o  (ld_aligned)
  );

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = rs2_q;
    case (width_q[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr_q[1:0];
        st_wdata = {4{rs2_q[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << addr_q[1:0];
        st_wdata = {2{rs2_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    busy         = (state_q != ST_IDLE);
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = '0;
    dmem_wdata   = '0;
    dmem_be      = '0;
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_uses_rd   = 1'b0;
    wb_data      = '0;
    wb_al_addr   = '0;
    wb_exception = 1'b0;
    case (state_q)
      ST_REQ: begin
        dmem_req  = 1'b1;
        dmem_we   = is_store_q;
        dmem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
        if (is_store_q == MEM_STORE) begin
          dmem_be    = st_be;
          dmem_wdata = st_wdata;
        end
      end
      ST_RESP: begin
        if (!killed_q && !kill) begin
          wb_valid     = 1'b1;
          wb_rd        = rd_q;
          wb_al_addr   = al_q;
          wb_exception = exc_q;
          wb_uses_rd   = (is_store_q == MEM_LOAD) && !exc_q && uses_rd_q;
          wb_data      = ((is_store_q == MEM_LOAD) && !exc_q) ? ld_data_q : 32'h0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_exec_unit.sv
// Scoreboard bench for mem_exec_unit: ops are modelled at issue, a monitor
// checks every dmem request and writeback against the queued expectation.
module tb_mem_exec_unit;
  import riscv_core::*;

  localparam int PR_W = 6;
  localparam int AL_W = 5;
  localparam int AW   = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            miq_valid = 1'b0, miq_uses_rd = 1'b0, miq_mem_access_type = 1'b0, kill = 1'b0;
  logic [PR_W-1:0] miq_rd = '0;
  logic [31:0]     miq_imm = '0, rs1_data = '0, rs2_data = '0;
  logic [2:0]      miq_width = '0;
  logic [AL_W-1:0] miq_al_addr = '0;
  logic            busy, dmem_req, dmem_we, wb_valid, wb_uses_rd, wb_exception;
  logic [AW-1:0]   dmem_addr;
  logic [31:0]     dmem_wdata, wb_data;
  logic [3:0]      dmem_be;
  logic            dmem_ack = 1'b0;
  logic [31:0]     dmem_rdata = '0;
  logic [PR_W-1:0] wb_rd;
  logic [AL_W-1:0] wb_al_addr;

  always #5 clk = ~clk;

  mem_exec_unit #(.ADDR_WIDTH(AW), .PR_W(PR_W), .AL_W(AL_W)) dut (
    .clk(clk), .reset(reset), .miq_valid(miq_valid), .miq_rd(miq_rd),
    .miq_uses_rd(miq_uses_rd), .miq_imm(miq_imm), .miq_mem_access_type(miq_mem_access_type),
    .miq_width(miq_width), .miq_al_addr(miq_al_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .kill(kill), .busy(busy), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_uses_rd(wb_uses_rd), .wb_data(wb_data),
    .wb_al_addr(wb_al_addr), .wb_exception(wb_exception)
  );

  typedef struct {
    logic            has_req;
    logic [31:0]     addr;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     wdata;
    logic            killed;
    logic [PR_W-1:0] rd;
    logic            uses_rd;
    logic [31:0]     data;
    logic [AL_W-1:0] al;
    logic            exc;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0, failures = 0;
  int          ack_wait = 0;
  logic        rdata_ovr_en = 1'b0;
  logic [31:0] rdata_ovr = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic bad(input string name);
    checks++;
    failures++;
    $display("FAIL %s (unexpected event)", name);
  endtask

  function automatic logic [31:0] rd_of(input logic [31:0] wa);
    return rdata_ovr_en ? rdata_ovr : (wa * 32'h9E3779B1 + 32'h7F4A7C15);
  endfunction

  // Reference: plain byte arithmetic over sizes and offsets.
  function automatic exp_t model(input logic st, input logic [2:0] w, input logic [31:0] rs1,
                                 input logic [31:0] imm, input logic [31:0] rs2,
                                 input logic [PR_W-1:0] rd, input logic uses, input logic [AL_W-1:0] al);
    exp_t e;
    int   size, off, m;
    logic [31:0] a, v;
    a   = rs1 + imm;
    off = int'(a[1:0]);
    case (w)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0) e.exc = 1'b1;
    else           e.exc = (off % size) != 0;
    e.has_req = !e.exc;
    e.addr    = a & ~32'h3;
    e.we      = st;
    e.be      = 4'b0;
    e.wdata   = 32'h0;
    if (st && size != 0) begin
      m = ((1 << size) - 1) << off;
      e.be = m[3:0];
      if (size == 1)      e.wdata = {24'b0, rs2[7:0]} * 32'h01010101;
      else if (size == 2) e.wdata = {16'b0, rs2[15:0]} * 32'h00010001;
      else                e.wdata = rs2;
    end
    v = rd_of(a & ~32'h3) >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (w == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (w == 3'd1 && v[15]) v = v | 32'hFFFF0000;
    end
    e.killed  = 1'b0;
    e.rd      = rd;
    e.al      = al;
    e.uses_rd = !st && !e.exc && uses;
    e.data    = (st || e.exc) ? 32'h0 : v;
    return e;
  endfunction

  // Memory responder: acks after ack_wait extra REQ cycles, noise outside REQ.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        dmem_ack = 1'b0;
        rcnt = 0;
      end else if (dmem_req) begin
        if (rcnt >= ack_wait) begin
          dmem_ack = 1'b1;
          dmem_rdata = rd_of(dmem_addr);
          rcnt = 0;
        end else begin
          dmem_ack = 1'b0;
          dmem_rdata = $urandom;
          rcnt++;
        end
      end else begin
        rcnt = 0;
        dmem_ack = ($urandom_range(0, 3) == 0);
        dmem_rdata = $urandom;
      end
    end
  end

  // Monitor
  logic exp_req_next = 1'b0, exp_wb_next = 1'b0, m_busy = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (reset) begin
      expq.delete();
      exp_req_next = 1'b0;
      exp_wb_next  = 1'b0;
      m_busy       = 1'b0;
    end else begin
      chk("busy", busy, m_busy);
      if (exp_req_next) begin
        chk("req_latency", dmem_req, 1);
        exp_req_next = 1'b0;
      end
      if (exp_wb_next) begin
        exp_wb_next = 1'b0;
        m_busy = 1'b0;
        if (expq.size() == 0) bad("wb_underflow");
        else begin
          me = expq.pop_front();
          chk("wb_valid", wb_valid, !me.killed);
          if (!me.killed) begin
            chk("wb_rd", wb_rd, me.rd);
            chk("wb_uses_rd", wb_uses_rd, me.uses_rd);
            chk("wb_data", wb_data, me.data);
            chk("wb_al_addr", wb_al_addr, me.al);
            chk("wb_exception", wb_exception, me.exc);
          end
        end
      end else if (wb_valid) bad("spurious_wb");
      if (dmem_req) begin
        if (expq.size() == 0 || !expq[0].has_req) bad("spurious_req");
        else begin
          chk("dmem_addr", dmem_addr, expq[0].addr);
          chk("dmem_we", dmem_we, expq[0].we);
          chk("dmem_be", dmem_be, expq[0].be);
          if (expq[0].we) chk("dmem_wdata", dmem_wdata, expq[0].wdata);
          if (dmem_ack) exp_wb_next = 1'b1;
        end
      end
      if (!busy && miq_valid && !kill) begin
        if (expq.size() == 0) bad("unexpected_accept");
        else begin
          m_busy = 1'b1;
          if (expq[0].has_req) exp_req_next = 1'b1;
          else                 exp_wb_next  = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic st, input logic [2:0] w, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] rs2, output exp_t e);
    miq_rd              = PR_W'($urandom);
    miq_al_addr         = AL_W'($urandom);
    miq_uses_rd         = 1'($urandom);
    miq_mem_access_type = st;
    miq_width           = w;
    rs1_data            = rs1;
    miq_imm             = imm;
    rs2_data            = rs2;
    e = model(st, w, rs1, imm, rs2, miq_rd, miq_uses_rd, miq_al_addr);
  endtask

  task automatic wait_idle(inout int lat);
    while (busy && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (busy) bad("idle_timeout");
  endtask

  task automatic issue(input logic st, input logic [2:0] w, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic [31:0] rs2, input int wait_c,
                       input logic kill_it, output int lat);
    exp_t e;
    lat = 0;
    wait_idle(lat);
    ack_wait = wait_c;
    drive(st, w, rs1, imm, rs2, e);
    e.killed = kill_it && e.has_req;
    expq.push_back(e);
    miq_valid = 1'b1;
    @(posedge clk); #1;
    miq_valid = 1'b0;
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    lat = 1;
    if (e.killed) begin
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      lat++;
    end
    wait_idle(lat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    exp_t e;
    logic st;
    logic [2:0] w;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    rdata_ovr_en = 1'b1;
    rdata_ovr = 32'hDEADBEEF;
    issue(MEM_LOAD, 3'b010, 32'h1000, 32'd4, 32'h0, 2, 1'b0, lat);
    chk("lw_wait2_cycles", lat, 5);
    rdata_ovr = 32'h80FFFFFF;
    issue(MEM_LOAD, 3'b000, 32'h1000, 32'd3, 32'h0, 0, 1'b0, lat);
    issue(MEM_LOAD, 3'b100, 32'h1000, 32'd3, 32'h0, 1, 1'b0, lat);
    rdata_ovr_en = 1'b0;
    issue(MEM_STORE, 3'b000, 32'h2000, 32'd2, 32'h123456AB, 0, 1'b0, lat);
    chk("zero_wait_cycles", lat, 3);
    issue(MEM_LOAD, 3'b010, 32'h3000, 32'd2, 32'h0, 0, 1'b0, lat);
    chk("exc_misaligned_cycles", lat, 2);
    issue(MEM_LOAD, 3'b011, 32'h3000, 32'd0, 32'h0, 0, 1'b0, lat);
    chk("exc_illegal_cycles", lat, 2);
    issue(MEM_LOAD, 3'b010, 32'h4000, 32'd8, 32'h0, 3, 1'b1, lat);
    chk("killed_cycles", lat, 6);
    issue(MEM_LOAD, 3'b001, 32'h4000, 32'd2, 32'h0, 0, 1'b0, lat);

    // kill in IDLE holds off acceptance for that cycle
    ack_wait = 0;
    drive(MEM_LOAD, 3'b101, 32'h5000, 32'd6, 32'h0, e);
    expq.push_back(e);
    miq_valid = 1'b1;
    kill = 1'b1;
    @(posedge clk); #1;
    chk("kill_idle_blocks", busy, 0);
    kill = 1'b0;
    @(posedge clk); #1;
    miq_valid = 1'b0;
    chk("accept_after_kill", busy, 1);
    lat = 1;
    wait_idle(lat);

    for (int i = 0; i < 150; i++) begin
      st = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) w = 3'($urandom_range(6, 8) % 8 == 0 ? 3 : $urandom_range(6, 7));
      else if (st) w = 3'($urandom_range(0, 2));
      else begin
        w = 3'($urandom_range(0, 4));
        if (w == 3'd3) w = 3'd5;
      end
      issue(st, w, $urandom, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom,
            $urandom, $urandom_range(0, 3), ($urandom_range(0, 7) == 0), lat);
    end

    // asynchronous reset in the middle of a request
    ack_wait = 20;
    drive(MEM_LOAD, 3'b010, 32'h6000, 32'd0, 32'h0, e);
    expq.push_back(e);
    miq_valid = 1'b1;
    @(posedge clk); #1;
    miq_valid = 1'b0;
    chk("req_before_reset", dmem_req, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_req", dmem_req, 0);
    chk("rst_async_busy", busy, 0);
    chk("rst_async_wb", wb_valid, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    issue(MEM_LOAD, 3'b010, 32'h7000, 32'd12, 32'h0, 1, 1'b0, lat);
    chk("lw_after_reset_cycles", lat, 4);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
